// File: rtl/shift_pkg.sv
// shift_pkg: shared definitions for the ALU shift/rotate result path.
//   - opcode encodings driven by the shifter
//   - result-buffer depth
//   - shift_entry_t: one buffered result with its capture-time flags
package shift_pkg;

   localparam logic [2:0] OP_SHR  = 3'b000;
   localparam logic [2:0] OP_SHRA = 3'b001;
   localparam logic [2:0] OP_SHL  = 3'b010;
   localparam logic [2:0] OP_ROR  = 3'b011;
   localparam logic [2:0] OP_ROL  = 3'b100;

   localparam int BUF_DEPTH = 2;
   localparam int RES_W     = 32;

   typedef struct packed {
      logic [RES_W-1:0] result;
      logic             zero;
      logic             neg;
      logic             carry;
   } shift_entry_t;

endpackage

// File: rtl/shift_flag_gen.sv
// shift_flag_gen: combinational flag computation for one shifter result.
// Ports:
//   i_result  shifter/rotator output
//   i_op      opcode (shift_pkg OP_*)
//   i_amt     shift amount mod 32
//   o_entry   result bundled with zero/neg/carry flags
// Carry is the last bit rotated through, so it only exists for rotates
// with a non-zero amount; shifts, zero-amount ops and illegal opcodes give 0.
module shift_flag_gen
   import shift_pkg::*;
(
   input  logic [RES_W-1:0] i_result,
   input  logic [2:0]       i_op,
   input  logic [4:0]       i_amt,
   output shift_entry_t     o_entry
);

   always_comb begin
      o_entry.result = i_result;
      o_entry.zero   = (i_result == '0);
      o_entry.neg    = i_result[RES_W-1];
      o_entry.carry  = 1'b0;
      if (i_amt != 5'd0) begin
         case (i_op)
            OP_ROR:                  o_entry.carry = i_result[RES_W-1];
            OP_ROL:                  o_entry.carry = i_result[0];
            OP_SHR, OP_SHRA, OP_SHL: o_entry.carry = 1'b0;
            default:                 o_entry.carry = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/alu_shift_result_buffer.sv
// alu_shift_result_buffer: 2-entry result FIFO between the combinational
// shifter and the Z-register writeback. Flags are computed at capture and
// stored with each entry; the output side is fully registered.
// Ports:
//   clk, clr_n           clock, asynchronous active-low reset
//   flush                synchronous clear of FIFO contents
//   in_valid/in_ready    upstream handshake (in_ready from registered count)
//   in_result/op/amt     shifter result, opcode, raw amount (amt[4:0] used)
//   out_valid/out_ready  downstream handshake
//   out_z, out_zero, out_neg, out_carry   head entry
//   stat_accepted, stat_stalls            statistics counters
// Optional feature macro: SHIFT_BUF_STATS_EN (statistics counters);
// when undefined the stat ports are tied to 0.
module alu_shift_result_buffer
   import shift_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = BUF_DEPTH,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic [2:0]        in_op,
   input  logic [DATA_W-1:0] in_amt,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_z,
   output logic              out_zero,
   output logic              out_neg,
   output logic              out_carry,
   output logic [CNT_W-1:0]  stat_accepted,
   output logic [CNT_W-1:0]  stat_stalls
);

   localparam logic [1:0] LP_DEPTH = 2'(DEPTH);

   shift_entry_t r_head;
   shift_entry_t r_tail;
   logic [1:0]   r_count;

   shift_entry_t w_new;
   logic         w_push;
   logic         w_pop;
   logic         w_unused_amt;

   // Amount is taken mod 32; upper operand bits are intentionally ignored.
   assign w_unused_amt = ^in_amt[DATA_W-1:5];

   shift_flag_gen u_flag_gen (
      .i_result (in_result),
      .i_op     (in_op),
      .i_amt    (in_amt[4:0]),
      .o_entry  (w_new)
   );

   assign in_ready  = (r_count < LP_DEPTH);
   assign out_valid = (r_count != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign out_z     = r_head.result;
   assign out_zero  = r_head.zero;
   assign out_neg   = r_head.neg;
   assign out_carry = r_head.carry;

   // Head is only rewritten on push-into-empty, push+pop, or promotion,
   // so it holds steady while the consumer stalls. Flush leaves head data
   // untouched; out_valid is what tells the consumer it is stale.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= 2'd0;
      end else if (flush) begin
         r_count <= 2'd0;
      end else begin
         case (r_count)
            2'd0: begin
               if (w_push) begin
                  r_head  <= w_new;
                  r_count <= 2'd1;
               end
            end
            2'd1: begin
               if (w_push && w_pop) begin
                  r_head <= w_new;
               end else if (w_push) begin
                  r_tail  <= w_new;
                  r_count <= 2'd2;
               end else if (w_pop) begin
                  r_count <= 2'd0;
               end
            end
            default: begin
               // Full: in_ready is low, so only a pop can happen here.
               if (w_pop) begin
                  r_head  <= r_tail;
                  r_count <= 2'd1;
               end
            end
         endcase
      end
   end

`ifdef SHIFT_BUF_STATS_EN
   localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_stat_acc;
   logic [CNT_W-1:0] r_stat_stall;

   // Saturating counters; cleared by reset only, not by flush.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_stat_acc   <= '0;
         r_stat_stall <= '0;
      end else begin
         if (w_push && (r_stat_acc != {CNT_W{1'b1}}))
            r_stat_acc <= r_stat_acc + LP_ONE;
         if (in_valid && !in_ready && (r_stat_stall != {CNT_W{1'b1}}))
            r_stat_stall <= r_stat_stall + LP_ONE;
      end
   end

   assign stat_accepted = r_stat_acc;
   assign stat_stalls   = r_stat_stall;
`else
   assign stat_accepted = '0;
   assign stat_stalls   = '0;
`endif

endmodule

// File: tb/tb_alu_shift_result_buffer.sv
module tb_alu_shift_result_buffer;

   localparam logic [2:0] SHR = 3'b000;
   localparam logic [2:0] SHL = 3'b010;
   localparam logic [2:0] ROR = 3'b011;
   localparam logic [2:0] ROL = 3'b100;

   logic        clk = 1'b0;
   logic        clr_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_result;
   logic [2:0]  in_op;
   logic [31:0] in_amt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_z;
   logic        out_zero;
   logic        out_neg;
   logic        out_carry;
   logic [15:0] stat_accepted;
   logic [15:0] stat_stalls;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_shift_result_buffer dut (
      .clk           (clk),
      .clr_n         (clr_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_result     (in_result),
      .in_op         (in_op),
      .in_amt        (in_amt),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_z         (out_z),
      .out_zero      (out_zero),
      .out_neg       (out_neg),
      .out_carry     (out_carry),
      .stat_accepted (stat_accepted),
      .stat_stalls   (stat_stalls)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] op,
                        input logic [31:0] amt);
      in_valid  = v;
      in_result = r;
      in_op     = op;
      in_amt    = amt;
   endtask

   // push one vector into an empty buffer with out_ready=1, check the
   // head flags one cycle later, then check it drains on the next edge
   task automatic single(input string tag, input logic [31:0] r, input logic [2:0] op,
                         input logic [31:0] amt, input logic [2:0] zno);
      out_ready = 1'b1;
      drive(1'b1, r, op, amt);
      step();
      drive(1'b0, 32'h0, SHR, 32'h0);
      chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".z"}, out_z, r);
      chk({tag, ".flags"}, {29'b0, out_zero, out_neg, out_carry}, {29'b0, zno});
      step();
      chk({tag, ".drain"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      clr_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'h0, SHR, 32'h0);
      #12;
      chk("rst.valid", {31'b0, out_valid}, 32'd0);
      chk("rst.ready", {31'b0, in_ready}, 32'd1);
      chk("rst.z", out_z, 32'h0);
      chk("rst.flags", {29'b0, out_zero, out_neg, out_carry}, 32'h0);
      chk("rst.stats", {stat_accepted, stat_stalls}, 32'h0);
      step();
      clr_n = 1'b1;
      step();

      // zero/neg/carry vectors
      single("ror1",   32'h8000_0000, ROR,    32'd1,  3'b011);
      single("ror32",  32'h0000_0000, ROR,    32'd32, 3'b100);
      single("rol3",   32'h0000_0001, ROL,    32'd3,  3'b001);
      single("shl4",   32'h8000_0001, SHL,    32'd4,  3'b010);
      single("illeg",  32'h0000_0001, 3'b111, 32'd5,  3'b000);
      single("rol0",   32'hFFFF_FFFF, ROL,    32'd64, 3'b010);

      // fill to two entries with consumer stalled
      out_ready = 1'b0;
      drive(1'b1, 32'h11, SHR, 32'd0);
      step();
      chk("fill1.ready", {31'b0, in_ready}, 32'd1);
      drive(1'b1, 32'h22, SHR, 32'd0);
      step();
      chk("fill2.ready", {31'b0, in_ready}, 32'd0);
      chk("fill2.head", out_z, 32'h11);
      drive(1'b1, 32'h33, SHR, 32'd0);
      step();
      chk("stall.head", out_z, 32'h11);
      chk("stall.ready", {31'b0, in_ready}, 32'd0);
      drive(1'b0, 32'h0, SHR, 32'd0);
      out_ready = 1'b1;
      step();
      chk("pop1.z", out_z, 32'h22);
      chk("pop1.valid", {31'b0, out_valid}, 32'd1);
      chk("pop1.ready", {31'b0, in_ready}, 32'd1);
      step();
      chk("pop2.valid", {31'b0, out_valid}, 32'd0);

      // simultaneous push and pop at count 1
      out_ready = 1'b0;
      drive(1'b1, 32'h55, SHR, 32'd0);
      step();
      drive(1'b1, 32'hAA, SHR, 32'd0);
      out_ready = 1'b1;
      step();
      drive(1'b0, 32'h0, SHR, 32'd0);
      chk("pp.z", out_z, 32'hAA);
      chk("pp.valid", {31'b0, out_valid}, 32'd1);
      chk("pp.ready", {31'b0, in_ready}, 32'd1);
      step();
      chk("pp.drain", {31'b0, out_valid}, 32'd0);

      // flush while full with a pending push
      out_ready = 1'b0;
      drive(1'b1, 32'h01, SHR, 32'd0);
      step();
      drive(1'b1, 32'h02, SHR, 32'd0);
      step();
      drive(1'b1, 32'h03, SHR, 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, SHR, 32'd0);
      chk("flush.valid", {31'b0, out_valid}, 32'd0);
      chk("flush.ready", {31'b0, in_ready}, 32'd1);
      chk("flush.zkeep", out_z, 32'h01);
      out_ready = 1'b1;
      step();
      chk("flush.after", {31'b0, out_valid}, 32'd0);
`ifdef SHIFT_BUF_STATS_EN
      // 6 singles + 2 + 2 + 2 pushes; stall cycles in fill and flush steps
      chk("stat.acc1", {16'b0, stat_accepted}, 32'd12);
      chk("stat.stall1", {16'b0, stat_stalls}, 32'd2);
`else
      chk("stat.tied", {stat_accepted, stat_stalls}, 32'h0);
`endif

      // flush beats a push into an empty buffer
      drive(1'b1, 32'h04, SHR, 32'd0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      drive(1'b0, 32'h0, SHR, 32'd0);
      chk("flush0.valid", {31'b0, out_valid}, 32'd0);

      // fresh reset, 5 pushes then 3 stall cycles, then async reset
      clr_n = 1'b0;
      #1;
      clr_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) out_ready = 1'b0;
         drive(1'b1, 32'h100 + i, SHR, 32'd0);
         step();
      end
      chk("burst.ready", {31'b0, in_ready}, 32'd0);
      drive(1'b1, 32'h200, SHR, 32'd0);
      for (int i = 0; i < 3; i++) step();
      chk("burst.head", out_z, 32'h103);
`ifdef SHIFT_BUF_STATS_EN
      chk("stat.acc5", {16'b0, stat_accepted}, 32'd5);
      chk("stat.stall3", {16'b0, stat_stalls}, 32'd3);
`endif
      #2;
      clr_n = 1'b0;
      #1;
      chk("arst.valid", {31'b0, out_valid}, 32'd0);
      chk("arst.z", out_z, 32'h0);
      chk("arst.ready", {31'b0, in_ready}, 32'd1);
      chk("arst.stats", {stat_accepted, stat_stalls}, 32'h0);
      drive(1'b0, 32'h0, SHR, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_shift_result_buffer.md
Name: alu_shift_result_buffer

Overview:
- Downstream stage of the ALU rotate/shift datapath.
- Captures each 32-bit shift/rotate result with its opcode and amount, and computes zero, negative and carry flags at capture.
- Holds results in a 2-entry FIFO with valid/ready handshakes on both sides, so the combinational shifter never stalls on Z-register writeback.
- Output is fully registered; the consumer is the Z register / writeback mux.

Parameters:
- DATA_W, 32, result width; only 32 is supported.
- DEPTH, 2, FIFO entries; only 2 is supported.
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- clr_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of FIFO contents
- in_valid  in  1  shifter result valid
- in_ready  out  1  buffer can accept
- in_result  in  32  shifter/rotator output
- in_op  in  3  opcode from shift_pkg (SHR, SHRA, SHL, ROR, ROL)
- in_amt  in  32  raw shift amount operand; only amt[4:0] is used (amount mod 32)
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer accepts head
- out_z  out  32  head result
- out_zero  out  1  head result == 0
- out_neg  out  1  head result[31]
- out_carry  out  1  last bit rotated through
- stat_accepted  out  CNT_W  accepted-result count (optional feature)
- stat_stalls  out  CNT_W  stall-cycle count (optional feature)

Behaviour:
- Clock and reset: one clock, clk. clr_n is asynchronous and active-low.
- Reset values: count=0, out_valid=0, out_z=0, all flags 0, stats=0.
- Acceptance:
  - in_ready = (count < 2), driven from registered state only; no combinational path from out_ready.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Latency: a result pushed into an empty buffer appears on out_* the next cycle.
- Flags, computed at push and stored with each entry:
  - zero = (in_result == 0).
  - neg = in_result[31].
  - carry, with M = in_amt[4:0]:
    - ROR with M≠0: carry = in_result[31].
    - ROL with M≠0: carry = in_result[0].
    - SHL/SHR/SHRA, or any op with M=0: carry = 0.
- Count transitions:
  - count 0: a push moves the entry to head; count becomes 1.
  - count 1: push and pop in the same cycle leaves count at 1 and loads the new entry to head. Push only → count 2. Pop only → count 0, out_valid=0.
  - count 2: push is blocked because in_ready=0. A pop promotes entry 1 to head; count becomes 1.
- Head stability: head contents and flags are held while out_valid=1 and out_ready=0.
- Flush: empties the FIFO next cycle (count=0, out_valid=0). Flush beats a push or pop in the same cycle, and the push is dropped. out_z keeps its last value; consumers qualify it with out_valid.
- Illegal opcodes are passed through unchanged, with carry=0.
- Reset mid-transfer discards all entries immediately.

Optional Feature:
- Macro: SHIFT_BUF_STATS_EN.
- With it defined:
  - stat_accepted increments on each push.
  - stat_stalls increments each cycle with in_valid=1 and in_ready=0.
  - Both saturate at all-ones, and both clear on clr_n but not on flush.
- Without it, the stat ports stay present and are tied to 0; no counter logic is generated.

Decomposition:
- shift_pkg holds:
  - opcode constants OP_SHR=3'b000, OP_SHRA=3'b001, OP_SHL=3'b010, OP_ROR=3'b011, OP_ROL=3'b100;
  - an entry struct or typedef {result[31:0], zero, neg, carry};
  - the DEPTH constant.
- One sub-module, shift_flag_gen: a combinational flag computation from result, op and amt.

Test Plan:
- ROR, in_result=0x8000_0000, amt=1, out_ready=1 → next cycle out_z=0x8000_0000, neg=1, carry=1, zero=0.
- ROR, amt=32 (M=0), in_result=0x0000_0000 → zero=1, carry=0, neg=0.
- Hold out_ready=0 and push 0x11, 0x22 → in_ready falls after the second push; a third push of 0x33 is not accepted; releasing out_ready yields 0x11 then 0x22 in order.
- With count=1, push 0xAA and pop in the same cycle → count stays 1, head becomes 0xAA, no loss or duplication.
- Flush asserted with count=2 and in_valid=1 → next cycle out_valid=0, in_ready=1, and the concurrent push is dropped.
- With SHIFT_BUF_STATS_EN defined, 5 pushes plus 3 stall cycles → stat_accepted=5, stat_stalls=3; asserting clr_n low mid-burst drives all outputs to 0 asynchronously.
